// File: rtl/dii_package.sv
// Shared debug-interconnect flit type used on the debug ring.
// A flit carries valid, end-of-packet marker and a 16-bit payload.
package dii_package;

   typedef struct packed {
      logic        valid;
      logic        last;
      logic [15:0] data;
   } dii_flit;

endpackage

// File: rtl/debug_ring_pkt_buffer.sv
// Store-and-forward packet buffer between the debug ring and a core segment.
// Ports: clk, rstn (async, active-low); flit_in/flit_in_ready upstream;
// flit_out/flit_out_ready downstream; level and pkt_count report occupancy;
// overflow_cut pulses when a full buffer with no complete packet is released.
module debug_ring_pkt_buffer
   import dii_package::*;
#(
   parameter int DEPTH       = 32,
   parameter int MAX_PKT_LEN = 16
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  dii_flit                flit_in,
   output logic                   flit_in_ready,
   output dii_flit                flit_out,
   input  logic                   flit_out_ready,
   output logic [$clog2(DEPTH):0] level,
   output logic [$clog2(DEPTH):0] pkt_count,
   output logic                   overflow_cut
);

   localparam int          AW   = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   if (DEPTH < MAX_PKT_LEN || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
      $error("DEPTH must be a power of two and >= MAX_PKT_LEN");
   end

   // Entry layout: {last, data}
   logic [16:0]   mem [DEPTH];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          cut_mode;

   logic [AW-1:0] wr_ptr_nxt;
   logic [AW-1:0] rd_ptr_nxt;
   logic [AW:0]   level_nxt;
   logic [AW:0]   pkt_count_nxt;
   logic          cut_mode_nxt;

   logic [16:0]   rd_word;
   logic          rd_last;
   logic          push;
   logic          pop;
   logic          cut_enter;
   logic          cut_active;
   logic          pkt_inc;
   logic          pkt_dec;

   assign rd_word = mem[rd_ptr];
   assign rd_last = rd_word[16];

   // Gated by rstn so nothing is accepted while reset is held.
   assign flit_in_ready = rstn && (level != FULL);

   // Full with no complete packet can never drain on its own, so the
   // partial packet is released cut-through; enter takes effect at once.
   assign cut_enter    = (level == FULL) && (pkt_count == '0) && !cut_mode;
   assign cut_active   = cut_mode || cut_enter;
   assign overflow_cut = cut_enter;

   assign flit_out.valid = (level != '0)
                         && ((pkt_count != '0) || cut_active);
   assign flit_out.last  = rd_last;
   assign flit_out.data  = rd_word[15:0];

   assign push    = flit_in.valid && flit_in_ready;
   assign pop     = flit_out.valid && flit_out_ready;
   assign pkt_inc = push && flit_in.last;
   assign pkt_dec = pop && rd_last;

   always_comb begin
      wr_ptr_nxt    = wr_ptr;
      rd_ptr_nxt    = rd_ptr;
      level_nxt     = level;
      pkt_count_nxt = pkt_count;
      cut_mode_nxt  = cut_mode;

      if (push) wr_ptr_nxt = wr_ptr + AW'(1);
      if (pop)  rd_ptr_nxt = rd_ptr + AW'(1);

      unique case ({push, pop})
         2'b10:   level_nxt = level + (AW+1)'(1);
         2'b01:   level_nxt = level - (AW+1)'(1);
         default: level_nxt = level;
      endcase

      unique case ({pkt_inc, pkt_dec})
         2'b10:   pkt_count_nxt = pkt_count + (AW+1)'(1);
         2'b01:   pkt_count_nxt = pkt_count - (AW+1)'(1);
         default: pkt_count_nxt = pkt_count;
      endcase

      if (cut_enter) cut_mode_nxt = 1'b1;
      // The released packet ends when its last flit leaves.
      if (cut_active && pkt_dec) cut_mode_nxt = 1'b0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         pkt_count <= '0;
         cut_mode  <= 1'b0;
      end else begin
         wr_ptr    <= wr_ptr_nxt;
         rd_ptr    <= rd_ptr_nxt;
         level     <= level_nxt;
         pkt_count <= pkt_count_nxt;
         cut_mode  <= cut_mode_nxt;
      end
   end

   // Storage has no reset; stale entries are unreachable after pointers clear.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {flit_in.last, flit_in.data};
   end

endmodule

// File: tb/tb_debug_ring_pkt_buffer.sv
// Bench for debug_ring_pkt_buffer: cycle vector table plus
// scoreboard-checked multi-cycle sequences.
module tb_debug_ring_pkt_buffer;
   import dii_package::*;

   logic       clk = 1'b0;
   logic       rstn;
   dii_flit    fin;
   logic       in_ready;
   dii_flit    fout;
   logic       ordy;
   logic [5:0] level;
   logic [5:0] pkt_count;
   logic       cut;

   int total  = 0;
   int passed = 0;
   int pushes = 0;
   int pops   = 0;
   int cuts   = 0;

   logic [16:0] sbq [$];

   always #5 clk = ~clk;

   debug_ring_pkt_buffer #(.DEPTH(32), .MAX_PKT_LEN(16)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .flit_in        (fin),
      .flit_in_ready  (in_ready),
      .flit_out       (fout),
      .flit_out_ready (ordy),
      .level          (level),
      .pkt_count      (pkt_count),
      .overflow_cut   (cut)
   );

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // Scoreboard: pop/compare before push so a same-cycle push never
   // stands in for the flit being read out.
   always @(negedge clk) begin
      if (rstn) begin
         if (fout.valid && ordy) begin
            if (sbq.size() == 0) begin
               chk("out_unexpected", 1, 0);
            end else begin
               logic [16:0] e;
               e = sbq.pop_front();
               chk("out_flit", int'({fout.last, fout.data}), int'(e));
            end
            pops++;
         end
         if (fin.valid && in_ready) begin
            sbq.push_back({fin.last, fin.data});
            pushes++;
         end
         if (cut) cuts++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_flit(input logic l, input logic [15:0] d,
                            input bit rnd);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      fin.valid = 1'b1;
      fin.last  = l;
      fin.data  = d;
      while (!done && n < 200) begin
         if (rnd) ordy = 1'($urandom_range(0, 1));
         @(negedge clk);
         done = in_ready;
         n++;
         tick();
      end
      fin.valid = 1'b0;
      fin.last  = 1'b0;
      if (!done) chk("push_timeout", 0, 1);
   endtask

   task automatic drain(input string nm, input int budget);
      int n;
      n = 0;
      ordy = 1'b1;
      while ((sbq.size() != 0 || level != 0) && n < budget) begin
         tick();
         n++;
      end
      chk({nm, "_drained"}, int'(n < budget), 1);
   endtask

   typedef struct {
      logic        in_v;
      logic        in_l;
      logic [15:0] in_d;
      logic        ordy;
      logic        e_ov;
      int          e_lvl;
      int          e_pc;
      logic        e_ir;
      logic        e_cut;
   } vec_t;

   vec_t vt [12];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int p0;

      // 3-flit packet, then simultaneous push-last / pop-last
      vt[0]  = '{1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0};
      vt[1]  = '{1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 1, 0, 1'b1, 1'b0};
      vt[2]  = '{1'b1, 1'b1, 16'h0003, 1'b1, 1'b0, 2, 0, 1'b1, 1'b0};
      vt[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 3, 1, 1'b1, 1'b0};
      vt[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 2, 1, 1'b1, 1'b0};
      vt[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1, 1, 1'b1, 1'b0};
      vt[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0};
      vt[7]  = '{1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0};
      vt[8]  = '{1'b1, 1'b1, 16'h0011, 1'b1, 1'b1, 1, 1, 1'b1, 1'b0};
      vt[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1, 1, 1'b1, 1'b0};
      vt[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1, 1, 1'b1, 1'b0};
      vt[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0};

      rstn = 1'b0;
      fin  = '0;
      ordy = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_level", int'(level), 0);
      chk("rst_pkt_count", int'(pkt_count), 0);
      chk("rst_out_valid", int'(fout.valid), 0);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_cut", int'(cut), 0);
      tick();
      rstn = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", int'(in_ready), 1);
      tick();

      for (int i = 0; i < 12; i++) begin
         fin.valid = vt[i].in_v;
         fin.last  = vt[i].in_l;
         fin.data  = vt[i].in_d;
         ordy      = vt[i].ordy;
         @(negedge clk);
         chk($sformatf("vec%0d_out_valid", i), int'(fout.valid),
             int'(vt[i].e_ov));
         chk($sformatf("vec%0d_level", i), int'(level), vt[i].e_lvl);
         chk($sformatf("vec%0d_pkt_count", i), int'(pkt_count),
             vt[i].e_pc);
         chk($sformatf("vec%0d_in_ready", i), int'(in_ready),
             int'(vt[i].e_ir));
         chk($sformatf("vec%0d_cut", i), int'(cut), int'(vt[i].e_cut));
         tick();
      end
      fin = '0;

      // Two back-to-back packets held, then released
      ordy = 1'b0;
      push_flit(1'b0, 16'hA000, 1'b0);
      push_flit(1'b1, 16'hA001, 1'b0);
      push_flit(1'b0, 16'hB000, 1'b0);
      push_flit(1'b0, 16'hB001, 1'b0);
      push_flit(1'b0, 16'hB002, 1'b0);
      push_flit(1'b1, 16'hB003, 1'b0);
      @(negedge clk);
      chk("b2b_pkt_count", int'(pkt_count), 2);
      chk("b2b_level", int'(level), 6);
      chk("b2b_out_valid", int'(fout.valid), 1);
      tick();
      p0 = pops;
      drain("b2b", 50);
      chk("b2b_pops", pops - p0, 6);

      // Full buffer with no last flit forces a cut-through release
      c0 = cuts;
      ordy = 1'b0;
      for (int i = 0; i < 32; i++) push_flit(1'b0, 16'h0100 + 16'(i), 1'b0);
      @(negedge clk);
      chk("full_level", int'(level), 32);
      chk("full_pkt_count", int'(pkt_count), 0);
      chk("full_in_ready", int'(in_ready), 0);
      chk("full_cut_pulse", int'(cut), 1);
      chk("full_out_valid", int'(fout.valid), 1);
      tick();
      @(negedge clk);
      chk("cut_pulse_ends", int'(cut), 0);
      tick();
      p0 = pops;
      drain("cut", 100);
      chk("cut_pops", pops - p0, 32);
      push_flit(1'b1, 16'h01FF, 1'b0);
      drain("cut_tail", 20);
      chk("cut_tail_pops", pops - p0, 33);
      chk("cut_pulse_count", cuts - c0, 1);

      // Single-flit packets with random backpressure across pointer wrap
      p0 = pops;
      for (int i = 0; i < 40; i++) push_flit(1'b1, 16'h2000 + 16'(i), 1'b1);
      drain("wrap", 200);
      chk("wrap_pops", pops - p0, 40);
      chk("wrap_level", int'(level), 0);

      // Reset mid-packet discards the partial packet
      ordy = 1'b1;
      push_flit(1'b0, 16'hC000, 1'b0);
      push_flit(1'b0, 16'hC001, 1'b0);
      chk("mid_level_before_rst", int'(level), 2);
      #2;
      rstn = 1'b0;
      #1;
      chk("mid_rst_level", int'(level), 0);
      chk("mid_rst_pkt_count", int'(pkt_count), 0);
      chk("mid_rst_out_valid", int'(fout.valid), 0);
      chk("mid_rst_in_ready", int'(in_ready), 0);
      sbq.delete();
      tick();
      rstn = 1'b1;
      @(negedge clk);
      chk("mid_post_rst_in_ready", int'(in_ready), 1);
      tick();
      p0 = pops;
      push_flit(1'b0, 16'hD000, 1'b0);
      push_flit(1'b1, 16'hD001, 1'b0);
      drain("after_rst", 20);
      chk("after_rst_pops", pops - p0, 2);
      chk("after_rst_pkt_count", int'(pkt_count), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/debug_ring_pkt_buffer.md
DEBUG_RING_PKT_BUFFER -- requirements
Module: debug_ring_pkt_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning flit storage entries (power of two, >= MAX_PKT_LEN).
REQ-002 SHALL have parameter MAX_PKT_LEN, default 16, meaning longest debug packet in flits.
REQ-003 SHALL have ports clk input 1 (single clock) and rstn input 1; reset is asynchronous, active-low.
REQ-004 SHALL have port flit_in  input  dii_flit, meaning ring flit from the upstream debug_system ring_out (valid, last, data[15:0]).
REQ-005 SHALL have port flit_in_ready  output  1, meaning the buffer accepts flit_in this cycle.
REQ-006 SHALL have port flit_out  output  dii_flit, meaning flit toward the downstream per-core ring segment.
REQ-007 SHALL have port flit_out_ready  input  1, meaning downstream accepts flit_out.
REQ-008 SHALL have port level  output  $clog2(DEPTH)+1, meaning flits currently stored.
REQ-009 SHALL have port pkt_count  output  $clog2(DEPTH)+1, meaning complete packets (last seen) stored.
REQ-010 SHALL have port overflow_cut  output  1, meaning a one-cycle pulse on each cut-through release (REQ-017).

Function
REQ-011 SHALL transfer a flit in only when flit_in.valid && flit_in_ready, and out only when flit_out.valid && flit_out_ready.
REQ-012 SHALL drive flit_in_ready = (level != DEPTH); no combinational path from flit_out_ready to flit_in_ready.
REQ-013 SHALL operate store-and-forward: flit_out.valid = (level != 0) && (pkt_count != 0 || cut_mode).
REQ-014 SHALL present flit_out.data/last from the entry at the read pointer; a flit written at cycle t is visible no earlier than t+1 (minimum latency 1 cycle).
REQ-015 SHALL increment pkt_count on an accepted flit with last=1, decrement it on a popped flit with last=1; both in the same cycle leave it unchanged.
REQ-016 SHALL update level by +1 on push, -1 on pop, unchanged on simultaneous push and pop.
REQ-017 SHALL enter cut_mode when level == DEPTH and pkt_count == 0 (no complete packet, deadlock risk), pulse overflow_cut for that cycle, and forward flits until the popped flit has last=1, then leave cut_mode.
REQ-018 SHALL wrap read and write pointers modulo DEPTH without lost or duplicated flits.
REQ-019 SHALL preserve flit order and the last flag exactly; data SHALL not be modified.
REQ-020 SHALL ignore flit_in.data/last when flit_in.valid=0; flit_out.data SHALL be don't-care when flit_out.valid=0.
REQ-021 SHALL hold flit_out stable while flit_out.valid && !flit_out_ready.

Reset
REQ-022 SHALL, while rstn=0, force flit_out.valid=0, flit_in_ready=0, level=0, pkt_count=0, overflow_cut=0, cut_mode=0, pointers=0.
REQ-023 SHALL discard all stored flits, including partial packets, on reset asserted mid-operation; storage contents need not be cleared.
REQ-024 SHALL drive flit_in_ready=1 in the first cycle after rstn deasserts.

Structure
REQ-025 SHALL reuse dii_flit from dii_package; no new shared typedefs or constants.
REQ-026 SHALL contain the storage array and control in one module; no sub-module is required.
REQ-027 SHALL be synthesizable as registers or distributed RAM with asynchronous read.

Verification
REQ-028 SHALL verify: 3-flit packet data 16'h0001,16'h0002,16'h0003(last) with out_ready=1 -> no out valid until cycle after last accepted, then 3 flits in order, pkt_count 1->0.
REQ-029 SHALL verify: two back-to-back packets (2 and 4 flits), out_ready=0 then 1 -> pkt_count=2, level=6, then all 6 flits in order with last on flits 2 and 6.
REQ-030 SHALL verify: DEPTH=32, 32 flits without last -> flit_in_ready=0, overflow_cut pulses once, 32 flits drain; next flit with last=1 then forwards.
REQ-031 SHALL verify: 40 packets of 1 flit (last=1) with random out_ready -> pointers wrap, no loss/duplication, level returns to 0.
REQ-032 SHALL verify: rstn=0 asserted after 2 of 4 flits of a packet -> level=0, pkt_count=0, flit_out.valid=0 immediately; subsequent packet forwards normally.
REQ-033 SHALL verify: simultaneous push of last-flit and pop of last-flit with pkt_count=1 -> pkt_count stays 1, level unchanged.
